// File: rtl/orb_pkg.sv
// Shared constants, state encoding and the word-content function for the
// Orbita frame filler family.
package orb_pkg;

    localparam int WORD_W     = 12;

    // Pointer widths for each frame format (FRAME_WORDS = 2**AW).
    localparam int ORB_M16_AW = 11;
    localparam int ORB_M8_AW  = 10;
    localparam int ORB_M4_AW  = 9;
    localparam int ORB_M2_AW  = 8;
    localparam int ORB_M1_AW  = 7;

    localparam logic [WORD_W-1:0] ORB_MARKER_DEF = 12'hE4B;

    typedef enum logic {
        ST_FIRST = 1'b0,
        ST_RUN   = 1'b1
    } orb_state_e;

    // Word content for a zero-extended pointer: marker, frame count, then ramp.
    function automatic logic [WORD_W-1:0] orb_word(
        input logic [WORD_W-1:0] ptr_ext,
        input logic [WORD_W-1:0] fc_lo,
        input logic [WORD_W-1:0] marker,
        input logic              ramp_en
    );
        logic [WORD_W-1:0] w;
        if (ptr_ext == 12'd0) begin
            w = marker;
        end else if (ptr_ext == 12'd1) begin
            w = fc_lo;
        end else if (ramp_en) begin
            w = ptr_ext + fc_lo;   // 12-bit wrap is intended
        end else begin
            w = 12'h000;
        end
        return w;
    endfunction

endpackage

// File: rtl/orb_req_sync.sv
// Slow-domain request level -> single fast-clock pulse. Two synchronizer
// flops, one history flop and a registered edge pulse, so a level first
// sampled high at edge k yields pulse_out high in the cycle after edge k+2.
module orb_req_sync (
    input  logic clk,
    input  logic reset,
    input  logic lvl_in,
    output logic pulse_out
);

    logic r_sync1;
    logic r_sync2;
    logic r_hist;
    logic r_pulse;

    // Synchronize the level, remember the previous value, register the rising edge.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_sync1 <= 1'b0;
            r_sync2 <= 1'b0;
            r_hist  <= 1'b0;
            r_pulse <= 1'b0;
        end else begin
            r_sync1 <= lvl_in;
            r_sync2 <= r_sync1;
            r_hist  <= r_sync2;
            r_pulse <= r_sync2 & ~r_hist;
        end
    end

    assign pulse_out = r_pulse;

endmodule

// File: rtl/orb_frame_filler.sv
// Deterministic word source for the Orbita frame formers. Serves marker,
// frame counter or ramp for each requested pointer, counts completed
// frames and flags pointer-sequence discontinuities.
module orb_frame_filler
    import orb_pkg::*;
#(
    parameter int                ADDR_W  = ORB_M16_AW,
    parameter logic [WORD_W-1:0] MARKER  = ORB_MARKER_DEF,
    parameter bit                RAMP_EN = 1'b1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              bufGetWord,
    input  logic [ADDR_W-1:0] bufRdPointer,
    output logic [11:0]       dataWord,
    output logic              wordStrobe,
    output logic [15:0]       frameCnt,
    output logic              seqErr,
    output logic [7:0]        errCnt
);

    // Pointers wider than the word cannot be zero-extended into the ramp.
    if (ADDR_W > WORD_W || ADDR_W < 1) begin : g_bad_addr_w
        $error("orb_frame_filler: ADDR_W must be in 1..12");
    end

    logic              w_req;
    logic [WORD_W-1:0] w_ptr_ext;
    logic [ADDR_W-1:0] w_expected;
    logic              w_is_last;
    logic              w_seq_bad;
    orb_state_e        w_state_nxt;

    orb_state_e        r_state;
    logic [ADDR_W-1:0] r_last_ptr;
    logic [11:0]       r_data_word;
    logic              r_word_strobe;
    logic [15:0]       r_frame_cnt;
    logic              r_seq_err;
    logic [7:0]        r_err_cnt;

    orb_req_sync u_req_sync (
        .clk       (clk),
        .reset     (reset),
        .lvl_in    (bufGetWord),
        .pulse_out (w_req)
    );

    assign w_ptr_ext  = WORD_W'(bufRdPointer);
    assign w_expected = r_last_ptr + ADDR_W'(1'b1);   // wraps at FRAME_WORDS
    assign w_is_last  = (bufRdPointer == {ADDR_W{1'b1}});

    // Next state and sequence check; the first request after reset is never checked.
    always_comb begin
        w_state_nxt = r_state;
        w_seq_bad   = 1'b0;
        case (r_state)
            ST_FIRST: begin
                if (w_req) begin
                    w_state_nxt = ST_RUN;
                end else begin
                    w_state_nxt = ST_FIRST;
                end
            end
            ST_RUN: begin
                w_state_nxt = ST_RUN;
                if (bufRdPointer != w_expected) begin
                    w_seq_bad = 1'b1;
                end else begin
                    w_seq_bad = 1'b0;
                end
            end
            default: begin
                w_state_nxt = ST_FIRST;
                w_seq_bad   = 1'b0;
            end
        endcase
    end

    // FSM state register.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= ST_FIRST;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Serve the word, advance frame count and track sequence errors on each request.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_last_ptr    <= '0;
            r_data_word   <= 12'h000;
            r_word_strobe <= 1'b0;
            r_frame_cnt   <= 16'h0000;
            r_seq_err     <= 1'b0;
            r_err_cnt     <= 8'h00;
        end else begin
            r_word_strobe <= 1'b0;
            r_seq_err     <= 1'b0;
            if (w_req) begin
                // Word at the final pointer carries the pre-increment count.
                r_data_word   <= orb_word(w_ptr_ext, r_frame_cnt[11:0], MARKER, RAMP_EN);
                r_word_strobe <= 1'b1;
                r_last_ptr    <= bufRdPointer;
                if (w_is_last) begin
                    r_frame_cnt <= r_frame_cnt + 16'd1;
                end
                if (w_state_nxt == ST_RUN && r_state == ST_RUN && w_seq_bad) begin
                    r_seq_err <= 1'b1;
                    if (r_err_cnt != 8'hFF) begin
                        r_err_cnt <= r_err_cnt + 8'd1;
                    end
                end
            end
        end
    end

    assign dataWord   = r_data_word;
    assign wordStrobe = r_word_strobe;
    assign frameCnt   = r_frame_cnt;
    assign seqErr     = r_seq_err;
    assign errCnt     = r_err_cnt;

endmodule

// File: tb/tb_orb_frame_filler.sv
// Directed, table-driven bench for orb_frame_filler: an M16 instance with
// default content and an M1 instance with ramp disabled and a custom marker.
module tb_orb_frame_filler;

    logic        clk;
    logic        reset;

    logic        get0;
    logic [10:0] ptr0;
    logic [11:0] dw0;
    logic        stb0;
    logic [15:0] fc0;
    logic        se0;
    logic [7:0]  ec0;

    logic        get1;
    logic [6:0]  ptr1;
    logic [11:0] dw1;
    logic        stb1;
    logic [15:0] fc1;
    logic        se1;
    logic [7:0]  ec1;

    int n_chk  = 0;
    int n_pass = 0;

    orb_frame_filler #(.ADDR_W(11)) dut0 (
        .clk          (clk),
        .reset        (reset),
        .bufGetWord   (get0),
        .bufRdPointer (ptr0),
        .dataWord     (dw0),
        .wordStrobe   (stb0),
        .frameCnt     (fc0),
        .seqErr       (se0),
        .errCnt       (ec0)
    );

    orb_frame_filler #(.ADDR_W(7), .MARKER(12'hABC), .RAMP_EN(1'b0)) dut1 (
        .clk          (clk),
        .reset        (reset),
        .bufGetWord   (get1),
        .bufRdPointer (ptr1),
        .dataWord     (dw1),
        .wordStrobe   (stb1),
        .frameCnt     (fc1),
        .seqErr       (se1),
        .errCnt       (ec1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Hard stop if something hangs.
    initial begin
        #10000000;
        $display("FAIL watchdog: simulation time limit reached, %0d/%0d checks passed", n_pass, n_chk);
        $fatal(1, "watchdog");
    end

    typedef struct {
        bit rst;
        bit slow;
        int ptr;
        int exp_dw;
        bit exp_se;
        int exp_ec;
        int exp_fc;
    } vec_t;

    vec_t tbl  [10];
    vec_t tbl1 [5];

    task automatic chk(input string name, input int act, input int exp);
        n_chk++;
        if (act == exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;
    endtask

    // Present ptr for lo cycles, raise the request for hi cycles, capture the served word.
    task automatic serve(input int inst, input int ptr, input int hi, input int lo,
                         output int dw, output bit se, output int lat, output int nstb);
        logic        s_stb;
        logic        s_se;
        logic [11:0] s_dw;
        if (inst == 0) ptr0 = ptr[10:0];
        else           ptr1 = ptr[6:0];
        repeat (lo) @(negedge clk);
        if (inst == 0) get0 = 1'b1;
        else           get1 = 1'b1;
        lat = -1; se = 1'b0; nstb = 0; dw = -1;
        for (int c = 1; c <= hi; c++) begin
            @(negedge clk);
            if (inst == 0) begin s_stb = stb0; s_se = se0; s_dw = dw0; end
            else           begin s_stb = stb1; s_se = se1; s_dw = dw1; end
            if (s_stb) begin
                nstb++;
                if (lat < 0) begin
                    lat = c - 1;
                    dw  = int'(s_dw);
                end
            end
            if (s_se) se = 1'b1;
        end
        if (inst == 0) get0 = 1'b0;
        else           get1 = 1'b0;
    endtask

    function automatic int model_word(input int p, input int fc, input int marker, input bit ramp);
        if (p == 0)      return marker;
        else if (p == 1) return fc % 4096;
        else if (ramp)   return (p + fc) % 4096;
        else             return 0;
    endfunction

    task automatic run_vec(input int inst, input vec_t v, input string tag);
        int dw, lat, nstb;
        bit se;
        if (v.rst) do_reset();
        serve(inst, v.ptr, v.slow ? 80 : 8, v.slow ? 80 : 6, dw, se, lat, nstb);
        chk({tag, " dataWord"}, dw, v.exp_dw);
        chk({tag, " seqErr"}, int'(se), int'(v.exp_se));
        chk({tag, " latency"}, lat, 3);
        chk({tag, " strobes"}, nstb, 1);
        if (inst == 0) begin
            chk({tag, " errCnt"}, int'(ec0), v.exp_ec);
            chk({tag, " frameCnt"}, int'(fc0), v.exp_fc);
        end else begin
            chk({tag, " errCnt"}, int'(ec1), v.exp_ec);
            chk({tag, " frameCnt"}, int'(fc1), v.exp_fc);
        end
    endtask

    initial begin
        int dw, lat, nstb, fcm, bad, errs, badlat, w1, w2, w2047_0, w2047_1, misses;
        bit se;

        //            rst   slow  ptr  dw       se    ec fc
        tbl[0] = '{1'b1, 1'b1,   0, 'hE4B, 1'b0, 0, 0};
        tbl[1] = '{1'b0, 1'b1,   1, 'h000, 1'b0, 0, 0};
        tbl[2] = '{1'b0, 1'b1,   2, 'h002, 1'b0, 0, 0};
        tbl[3] = '{1'b0, 1'b1,   3, 'h003, 1'b0, 0, 0};
        tbl[4] = '{1'b1, 1'b0,   5, 'h005, 1'b0, 0, 0};
        tbl[5] = '{1'b0, 1'b0,   6, 'h006, 1'b0, 0, 0};
        tbl[6] = '{1'b0, 1'b0,   9, 'h009, 1'b1, 1, 0};
        tbl[7] = '{1'b0, 1'b0,   9, 'h009, 1'b1, 2, 0};
        tbl[8] = '{1'b0, 1'b0, 100, 'h064, 1'b1, 3, 0};
        tbl[9] = '{1'b0, 1'b0,   0, 'hE4B, 1'b1, 4, 0};

        // M1 instance: ramp off, marker ABC, wrap 127 -> 0.
        tbl1[0] = '{1'b0, 1'b0, 126, 'h000, 1'b0, 0, 0};
        tbl1[1] = '{1'b0, 1'b0, 127, 'h000, 1'b0, 0, 1};
        tbl1[2] = '{1'b0, 1'b0,   0, 'hABC, 1'b0, 0, 1};
        tbl1[3] = '{1'b0, 1'b0,   1, 'h001, 1'b0, 0, 1};
        tbl1[4] = '{1'b0, 1'b0,   2, 'h000, 1'b0, 0, 1};

        reset = 1'b1; get0 = 1'b0; get1 = 1'b0; ptr0 = '0; ptr1 = '0;
        repeat (4) @(negedge clk);
        chk("reset dataWord", int'(dw0), 0);
        chk("reset wordStrobe", int'(stb0), 0);
        chk("reset frameCnt", int'(fc0), 0);
        chk("reset seqErr", int'(se0), 0);
        chk("reset errCnt", int'(ec0), 0);
        reset = 1'b0;

        // First words of a frame, slow handshake.
        for (int i = 0; i < 4; i++) run_vec(0, tbl[i], $sformatf("t1[%0d]", i));

        // Finish frame 0 and run frame 1 completely.
        fcm = 0; w1 = -1; w2 = -1; w2047_0 = -1; w2047_1 = -1;
        for (int f = 0; f < 2; f++) begin
            bad = 0; errs = 0; badlat = 0;
            for (int p = (f == 0) ? 4 : 0; p < 2048; p++) begin
                serve(0, p, 8, 6, dw, se, lat, nstb);
                if (dw != model_word(p, fcm, 'hE4B, 1'b1)) bad++;
                if (se) errs++;
                if (lat != 3 || nstb != 1) badlat++;
                if (f == 0 && p == 2047) w2047_0 = dw;
                if (f == 1 && p == 1)    w1 = dw;
                if (f == 1 && p == 2)    w2 = dw;
                if (f == 1 && p == 2047) w2047_1 = dw;
                if (p == 2047) fcm++;
            end
            chk($sformatf("frame%0d wrong words", f), bad, 0);
            chk($sformatf("frame%0d seqErr count", f), errs, 0);
            chk($sformatf("frame%0d timing errors", f), badlat, 0);
            chk($sformatf("frame%0d frameCnt", f), int'(fc0), f + 1);
        end
        chk("frame0 word2047", w2047_0, 'h7FF);
        chk("frame1 word1", w1, 'h001);
        chk("frame1 word2", w2, 'h003);
        chk("frame1 word2047", w2047_1, 'h800);
        chk("frames errCnt", int'(ec0), 0);

        // Discontinuities and jump to zero.
        for (int i = 4; i < 10; i++) run_vec(0, tbl[i], $sformatf("t3[%0d]", i));

        // Saturation of the error counter.
        misses = 0;
        for (int k = 1; k <= 300; k++) begin
            serve(0, 7, 8, 6, dw, se, lat, nstb);
            if (!se || dw != 'h007) misses++;
            if (k == 250) chk("sat errCnt@250", int'(ec0), 254);
            if (k == 251) chk("sat errCnt@251", int'(ec0), 255);
        end
        chk("sat errCnt@300", int'(ec0), 255);
        chk("sat missing seqErr", misses, 0);
        do_reset();
        chk("post-reset errCnt", int'(ec0), 0);
        chk("post-reset dataWord", int'(dw0), 0);
        chk("post-reset frameCnt", int'(fc0), 0);
        serve(0, 50, 8, 6, dw, se, lat, nstb);
        chk("post-reset word", dw, 'h032);
        chk("post-reset seqErr", int'(se), 0);
        serve(0, 51, 8, 6, dw, se, lat, nstb);
        chk("post-reset 2nd word", dw, 'h033);

        // Reset pulse while the request level is high.
        ptr0 = 11'd52;
        repeat (6) @(negedge clk);
        get0 = 1'b1;
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        chk("midreq dataWord", int'(dw0), 0);
        chk("midreq wordStrobe", int'(stb0), 0);
        chk("midreq seqErr", int'(se0), 0);
        chk("midreq errCnt", int'(ec0), 0);
        reset = 1'b0;
        lat = -1; nstb = 0; se = 1'b0; dw = -1;
        for (int c = 1; c <= 12; c++) begin
            @(negedge clk);
            if (stb0) begin
                nstb++;
                if (lat < 0) begin lat = c - 1; dw = int'(dw0); end
            end
            if (se0) se = 1'b1;
        end
        get0 = 1'b0;
        chk("midreq latency", lat, 3);
        chk("midreq strobes", nstb, 1);
        chk("midreq word", dw, 'h034);
        chk("midreq seqErr after", int'(se), 0);

        // Small format instance.
        for (int i = 0; i < 5; i++) run_vec(1, tbl1[i], $sformatf("m1[%0d]", i));

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
